alu_sequencer: RTL

Multi-cycle control sequencer that drives the 13-bit ALU. It is the issuing end of the ALU's `ALU_Op`/`ALU_IN1`/`ALU_IN2` → `ALU_Result`/`BEQ` interface. It accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 8×13 register file. It drives the ALU, samples its result, and then writes back the register file or updates the PC. It sits between instruction fetch and the ALU in the ECE176 datapath.

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_seq_regfile.sv | 41 ++++
 rtl/alu_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states, instruction field positions and width defaults for alu_sequencer
package alu_seq_pkg;
   localparam int DATA_W_DEF = 13;
   localparam int PC_W_DEF   = 8;
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_ADDI = 3'b010;
   localparam logic [2:0] OP_SUBI = 3'b011;
   localparam logic [2:0] OP_BR   = 3'b100;
   localparam logic [2:0] OP_BEQ  = 3'b101;
   localparam logic [2:0] OP_FADD = 3'b110;
   localparam logic [2:0] OP_FSUB = 3'b111;
   localparam int OP_HI = 15, OP_LO = 13;
   localparam int RD_HI = 12, RD_LO = 10;
   localparam int RS_HI = 9,  RS_LO = 7;
   localparam int RT_HI = 6,  RT_LO = 4;
   localparam int IMM_HI = 6, IMM_LO = 0;
   typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
   function automatic logic writes_reg(input logic [2:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, OP_FADD, OP_FSUB: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction
endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: NREG x DATA_W register file, R0 hardwired to zero
//   clk/reset          clock, synchronous active-high clear of all registers
//   we/waddr/wdata     synchronous write port
//   raddr_a/rdata_a    asynchronous read port A
//   raddr_b/rdata_b    asynchronous read port B
//   ALU_SEQ_OVERLAP_EN adds a write-first bypass onto both read ports
module alu_seq_regfile
   import alu_seq_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int NREG   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [2:0]        waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [2:0]        raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [2:0]        raddr_b,
   output logic [DATA_W-1:0] rdata_b
);
   logic [DATA_W-1:0] r_mem [NREG];
   logic [DATA_W-1:0] w_a, w_b;
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
      end else if (we && waddr != 3'd0) begin
         r_mem[waddr] <= wdata;
      end
   end
   assign w_a = (raddr_a == 3'd0) ? '0 : r_mem[raddr_a];
   assign w_b = (raddr_b == 3'd0) ? '0 : r_mem[raddr_b];
`ifdef ALU_SEQ_OVERLAP_EN
   assign rdata_a = (we && waddr == raddr_a && raddr_a != 3'd0) ? wdata : w_a;
   assign rdata_b = (we && waddr == raddr_b && raddr_b != 3'd0) ? wdata : w_b;
`else
   assign rdata_a = w_a;
   assign rdata_b = w_b;
`endif
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: 4-state sequencer issuing instructions to the 13-bit ALU
//   clk/reset                  clock, synchronous active-high reset
//   instr_valid/instr_ready    instruction handshake, instr = {op,rd,rs,rt|imm7}
//   pc                         program counter
//   ALU_Op/ALU_IN1/ALU_IN2     registered ALU request, stable through EXEC and WB
//   ALU_Result/BEQ             ALU response, sampled in WB
//   wb_valid/wb_addr/wb_data   register write pulse in WB
//   busy                       high outside IDLE
//   ALU_SEQ_OVERLAP_EN         accepts the next instruction during WB (3 cycles/instr)
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int PC_W   = PC_W_DEF,
   parameter int NREG   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [15:0]       instr,
   output logic [PC_W-1:0]   pc,
   output logic [2:0]        ALU_Op,
   output logic [DATA_W-1:0] ALU_IN1,
   output logic [DATA_W-1:0] ALU_IN2,
   input  logic [DATA_W-1:0] ALU_Result,
   input  logic              BEQ,
   output logic              wb_valid,
   output logic [2:0]        wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic              busy
);
   state_t            r_state, w_next;
   logic [15:0]       r_instr;
   logic [PC_W-1:0]   r_pc;
   logic [2:0]        r_alu_op;
   logic [DATA_W-1:0] r_in1, r_in2;
   logic [2:0]        w_op, w_rd, w_rs, w_rt;
   logic [6:0]        w_imm7;
   logic [DATA_W-1:0] w_sext, w_rda, w_rdb;
   logic              w_hs, w_wb;
   assign w_op   = r_instr[OP_HI:OP_LO];
   assign w_rd   = r_instr[RD_HI:RD_LO];
   assign w_rs   = r_instr[RS_HI:RS_LO];
   assign w_rt   = r_instr[RT_HI:RT_LO];
   assign w_imm7 = r_instr[IMM_HI:IMM_LO];
   assign w_sext = {{(DATA_W-7){w_imm7[6]}}, w_imm7};
   assign w_hs   = instr_valid && instr_ready;
   // BEQ compares R[rd] with R[rs], so port A is steered to rd for that op
   alu_seq_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
      .clk     (clk),
      .reset   (reset),
      .we      (w_wb),
      .waddr   (w_rd),
      .wdata   (ALU_Result),
      .raddr_a (w_op == OP_BEQ ? w_rd : w_rs),
      .rdata_a (w_rda),
      .raddr_b (w_op == OP_BEQ ? w_rs : w_rt),
      .rdata_b (w_rdb)
   );
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end
   // WB only sees a handshake when overlap makes instr_ready high there
   always_comb begin
      w_next = r_state == IDLE   ? (w_hs ? DECODE : IDLE) :
               r_state == DECODE ? EXEC :
               r_state == EXEC   ? WB :
                                   (w_hs ? DECODE : IDLE);
   end
   always_comb begin
`ifdef ALU_SEQ_OVERLAP_EN
      instr_ready = !reset && (r_state == IDLE || r_state == WB);
`else
      instr_ready = !reset && r_state == IDLE;
`endif
      busy     = r_state != IDLE;
      w_wb     = r_state == WB && writes_reg(w_op) && w_rd != 3'd0 && !reset;
      wb_valid = w_wb;
      wb_addr  = w_wb ? w_rd : 3'd0;
      wb_data  = w_wb ? ALU_Result : '0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_instr  <= '0;
         r_pc     <= '0;
         r_alu_op <= '0;
         r_in1    <= '0;
         r_in2    <= '0;
      end else begin
         if (w_hs) r_instr <= instr;
         if (r_state == DECODE) begin
            r_alu_op <= w_op;
            r_in1    <= w_op == OP_BR ? {{(DATA_W-PC_W){1'b0}}, r_pc} : w_rda;
            r_in2    <= (w_op == OP_BR || w_op == OP_ADDI || w_op == OP_SUBI) ? w_sext : w_rdb;
         end
         if (r_state == WB)
            r_pc <= w_op == OP_BR           ? ALU_Result[PC_W-1:0] :
                    (w_op == OP_BEQ && BEQ) ? r_pc + w_sext[PC_W-1:0] :
                                              r_pc + 1'b1;
      end
   end
   assign pc      = r_pc;
   assign ALU_Op  = r_alu_op;
   assign ALU_IN1 = r_in1;
   assign ALU_IN2 = r_in2;
endmodule
